// File: rtl/spi_memory_master_if.sv
// Command-side bus of the SPI memory master: the fabric raises a command,
// the master reports progress and returns the captured read byte.
interface spi_memory_master_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_memory_master.sv
// Mode-0 SPI master that sends one 16-bit frame {addr, rw, data} per command
// and returns the second MISO byte of a read frame on rdata.
module spi_memory_master #(
    parameter int CLK_DIV = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    spi_memory_master_if.slave         cmd,
    output logic                       sclk_pin,
    output logic                       cs_pin,
    output logic                       mosi_pin,
    input  logic                       miso_pin
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        GAP,
        DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        last_bit_q, last_bit_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] rx_q, rx_d;
    logic        is_read_q, is_read_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        div_end;

    assign div_end = (div_cnt_q == DIV_LAST);

    // Every phase of the frame lasts CLK_DIV cycles; div_cnt times the phase.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        shift_d    = shift_q;
        rx_d       = rx_q;
        is_read_d  = is_read_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;

        case (state_q)
            IDLE: begin
                if (cmd.start) begin
                    shift_d    = {cmd.addr, cmd.rw, (cmd.rw ? 8'h00 : cmd.wdata)};
                    is_read_d  = cmd.rw;
                    busy_d     = 1'b1;
                    cs_d       = 1'b0;
                    mosi_d     = cmd.addr[6];
                    div_cnt_d  = 8'd0;
                    bit_cnt_d  = 4'd0;
                    last_bit_d = 1'b0;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                if (div_end) begin
                    div_cnt_d = 8'd0;
                    sclk_d    = 1'b1;
                    state_d   = SCLK_HI;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            // MISO is taken just before the falling edge; MOSI moves on that edge.
            SCLK_HI: begin
                if (div_end) begin
                    div_cnt_d  = 8'd0;
                    rx_d       = {rx_q[14:0], miso_pin};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    last_bit_d = (bit_cnt_q == 4'd15);
                    shift_d    = {shift_q[14:0], 1'b0};
                    mosi_d     = shift_q[14];
                    sclk_d     = 1'b0;
                    state_d    = SCLK_LO;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            SCLK_LO: begin
                if (div_end) begin
                    div_cnt_d = 8'd0;
                    if (last_bit_q) begin
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        sclk_d  = 1'b1;
                        state_d = SCLK_HI;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            GAP: begin
                if (div_end) begin
                    div_cnt_d = 8'd0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    if (is_read_q) begin
                        rdata_d = rx_q[7:0];
                    end
                    state_d = DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            DONE: begin
                last_bit_d = 1'b0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset abandons any frame at once: CS rises and SCLK drops without a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= 8'd0;
            bit_cnt_q  <= 4'd0;
            last_bit_q <= 1'b0;
            shift_q    <= 16'h0000;
            rx_q       <= 16'h0000;
            is_read_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= 8'h00;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            shift_q    <= shift_d;
            rx_q       <= rx_d;
            is_read_q  <= is_read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
        end
    end

    assign cmd.busy  = busy_q;
    assign cmd.done  = done_q;
    assign cmd.rdata = rdata_q;
    assign sclk_pin  = sclk_q;
    assign cs_pin    = cs_q;
    assign mosi_pin  = mosi_q;

endmodule

// File: tb/tb_spi_memory_master.sv
// Bench for spi_memory_master: two instances (CLK_DIV 4 and 2) checked every
// cycle against a cycle-offset model of the frame, plus fixed literal cases.
module tb_spi_memory_master;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    spi_memory_master_if if4 ();
    spi_memory_master_if if2 ();

    logic sclk4, cs4, mosi4, miso4;
    logic sclk2, cs2, mosi2, miso2;

    spi_memory_master #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .cmd(if4),
        .sclk_pin(sclk4), .cs_pin(cs4), .mosi_pin(mosi4), .miso_pin(miso4)
    );

    spi_memory_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .cmd(if2),
        .sclk_pin(sclk2), .cs_pin(cs2), .mosi_pin(mosi2), .miso_pin(miso2)
    );

    logic [1:0] start_v, rw_v;
    logic [6:0] addr_v [2];
    logic [7:0] wdata_v [2];
    logic [7:0] sbyte [2];

    assign if4.start = start_v[0];
    assign if4.rw    = rw_v[0];
    assign if4.addr  = addr_v[0];
    assign if4.wdata = wdata_v[0];
    assign if2.start = start_v[1];
    assign if2.rw    = rw_v[1];
    assign if2.addr  = addr_v[1];
    assign if2.wdata = wdata_v[1];

    logic [1:0] cs_v, sclk_v, mosi_v, busy_v, done_v;
    logic [7:0] rdata_v [2];
    assign cs_v       = {cs2, cs4};
    assign sclk_v     = {sclk2, sclk4};
    assign mosi_v     = {mosi2, mosi4};
    assign busy_v     = {if2.busy, if4.busy};
    assign done_v     = {if2.done, if4.done};
    assign rdata_v[0] = if4.rdata;
    assign rdata_v[1] = if2.rdata;

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // Slave model: counts SCLK falls in the frame and serves its byte in bits 8..15.
    int nf4 = 0;
    int nf2 = 0;
    always @(negedge sclk4 or posedge cs4) nf4 <= cs4 ? 0 : nf4 + 1;
    always @(negedge sclk2 or posedge cs2) nf2 <= cs2 ? 0 : nf2 + 1;
    assign miso4 = (!cs4 && nf4 >= 8 && nf4 < 16) ? sbyte[0][3'(15 - nf4)] : 1'b0;
    assign miso2 = (!cs2 && nf2 >= 8 && nf2 < 16) ? sbyte[1][3'(15 - nf2)] : 1'b0;

    logic [15:0] mcap4 = 16'h0000;
    int rises4 = 0;
    int rises2 = 0;
    always @(posedge sclk4 or negedge cs4) begin
        if (sclk4) begin
            mcap4  <= {mcap4[14:0], mosi4};
            rises4 <= rises4 + 1;
        end else begin
            mcap4  <= 16'h0000;
            rises4 <= 0;
        end
    end
    always @(posedge sclk2 or negedge cs2) rises2 <= sclk2 ? rises2 + 1 : 0;

    logic [1:0] cs_prev = 2'b11;
    int cslow [2] = '{0, 0};
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cs_v[i]) cslow[i] <= cs_prev[i] ? 1 : cslow[i] + 1;
        end
        cs_prev <= cs_v;
    end

    // Reference: m_k is the number of clk edges since the accepting edge.
    logic        m_active [2];
    int          m_k [2];
    logic [15:0] m_frame [2];
    logic        m_read [2];
    logic [7:0]  m_rdata [2];
    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_active[i] <= 1'b0;
                m_k[i]      <= 0;
                m_rdata[i]  <= 8'h00;
            end else if (m_active[i]) begin
                if (m_k[i] == 34 * div_of(i)) begin
                    m_active[i] <= 1'b0;
                end else begin
                    m_k[i] <= m_k[i] + 1;
                    if (m_k[i] + 1 == 34 * div_of(i) && m_read[i]) m_rdata[i] <= sbyte[i];
                end
            end else if (start_v[i]) begin
                m_active[i] <= 1'b1;
                m_k[i]      <= 0;
                m_read[i]   <= rw_v[i];
                m_frame[i]  <= {addr_v[i], rw_v[i], (rw_v[i] ? 8'h00 : wdata_v[i])};
            end
        end
    end

    task automatic check_output(input string name, input int inst,
                                input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t",
                     name, inst, actual, expected, $time);
        end
    endtask

    task automatic compare_loop();
        int d, k, p, b;
        logic [15:0] fr;
        logic e_cs, e_sclk, e_mosi, e_busy, e_done;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                d = div_of(i);
                e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
                if (m_active[i]) begin
                    k  = m_k[i];
                    fr = m_frame[i];
                    if (k == 34 * d) begin
                        e_done = 1'b1;
                    end else begin
                        e_busy = 1'b1;
                        if (k < 33 * d) begin
                            e_cs = 1'b0;
                            if (k < d) begin
                                e_mosi = fr[15];
                            end else begin
                                p = (k - d) / d;
                                b = p / 2;
                                if (p % 2 == 0) begin
                                    e_sclk = 1'b1;
                                    e_mosi = fr[4'(15 - b)];
                                end else begin
                                    e_mosi = (b < 15) ? fr[4'(14 - b)] : 1'b0;
                                end
                            end
                        end
                    end
                end
                check_output("cs_pin", i, cs_v[i], e_cs);
                check_output("sclk_pin", i, sclk_v[i], e_sclk);
                check_output("mosi_pin", i, mosi_v[i], e_mosi);
                check_output("busy", i, busy_v[i], e_busy);
                check_output("done", i, done_v[i], e_done);
                check_output("rdata", i, rdata_v[i], m_rdata[i]);
            end
        end
    endtask

    task automatic apply_stimulus(input int i, input logic rw, input logic [6:0] a,
                                  input logic [7:0] w, input logic [7:0] sb,
                                  input bit glitch, output int lat);
        @(negedge clk);
        sbyte[i]   = sb;
        rw_v[i]    = rw;
        addr_v[i]  = a;
        wdata_v[i] = w;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        lat = 0;
        while (done_v[i] !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (glitch) start_v[i] = ($urandom_range(0, 7) == 0);
        end
        start_v[i] = 1'b0;
        if (lat >= 2000) check_output("done_timeout", i, 0, 1);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_output("idle_timeout", i, 0, 1);
    endtask

    initial begin
        int lat, t, falls, hi_run, min_hi;
        int tf [3];
        logic prev;
        logic [7:0] prev_rd [2];
        logic [7:0] sb;
        logic rw;
        int i;

        reset_n = 1'b0;
        start_v = 2'b00;
        rw_v    = 2'b00;
        addr_v  = '{7'h00, 7'h00};
        wdata_v = '{8'h00, 8'h00};
        sbyte   = '{8'h00, 8'h00};
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check_output("reset_cs", j, cs_v[j], 1);
            check_output("reset_sclk", j, sclk_v[j], 0);
            check_output("reset_mosi", j, mosi_v[j], 0);
            check_output("reset_busy", j, busy_v[j], 0);
            check_output("reset_rdata", j, rdata_v[j], 8'h00);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] write 2A <- C5");
        apply_stimulus(0, 1'b0, 7'h2A, 8'hC5, 8'hFF, 1'b0, lat);
        check_output("wr_done_latency", 0, lat, 136);
        check_output("wr_mosi_bits", 0, mcap4, 16'h54C5);
        check_output("wr_sclk_rises", 0, rises4, 16);
        check_output("wr_cs_low", 0, cslow[0], 132);
        check_output("wr_rdata_kept", 0, rdata_v[0], 8'h00);

        $display("[TB] read 2A, slave returns C5");
        apply_stimulus(0, 1'b1, 7'h2A, 8'h3C, 8'hC5, 1'b0, lat);
        check_output("rd_addr_byte", 0, mcap4[15:8], 8'h55);
        check_output("rd_data_bits", 0, mcap4[7:0], 8'h00);
        check_output("rd_rdata", 0, rdata_v[0], 8'hC5);
        check_output("rd_busy", 0, busy_v[0], 0);

        $display("[TB] start pulse mid-frame and start held high");
        @(negedge clk);
        sbyte[0] = 8'h00; rw_v[0] = 1'b0; addr_v[0] = 7'h15; wdata_v[0] = 8'h99;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (40) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);
        check_output("no_queued_frame", 0, busy_v[0], 0);

        start_v[0] = 1'b1;
        falls = 0; t = 0; hi_run = 0; min_hi = 1000; prev = cs4;
        tf = '{0, 0, 0};
        while (falls < 3 && t < 1000) begin
            @(negedge clk);
            t++;
            if (prev && !cs4) begin
                if (falls >= 1 && hi_run < min_hi) min_hi = hi_run;
                tf[falls] = t;
                falls++;
            end
            hi_run = cs4 ? hi_run + 1 : 0;
            prev = cs4;
        end
        start_v[0] = 1'b0;
        check_output("held_frames", 0, falls, 3);
        check_output("held_period_a", 0, tf[1] - tf[0], 138);
        check_output("held_period_b", 0, tf[2] - tf[1], 138);
        check_output("held_cs_gap_ge4", 0, (min_hi >= 4) ? 1 : 0, 1);
        wait_idle(0);
        repeat (2) @(negedge clk);

        $display("[TB] reset during read");
        @(negedge clk);
        sbyte[0] = 8'hA7; rw_v[0] = 1'b1; addr_v[0] = 7'h33; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (60) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_cs", 0, cs4, 1);
        check_output("async_sclk", 0, sclk4, 0);
        check_output("async_busy", 0, busy_v[0], 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_output("rst_rdata", 0, rdata_v[0], 8'h00);
        apply_stimulus(0, 1'b1, 7'h11, 8'h00, 8'h5A, 1'b0, lat);
        check_output("post_rst_latency", 0, lat, 136);
        check_output("post_rst_rdata", 0, rdata_v[0], 8'h5A);

        $display("[TB] CLK_DIV=2 read of 81");
        apply_stimulus(1, 1'b1, 7'h40, 8'h00, 8'h81, 1'b0, lat);
        check_output("d2_latency", 1, lat, 68);
        check_output("d2_rdata", 1, rdata_v[1], 8'h81);
        check_output("d2_cs_low", 1, cslow[1], 66);
        check_output("d2_sclk_rises", 1, rises2, 16);

        $display("[TB] randomized commands");
        prev_rd[0] = rdata_v[0];
        prev_rd[1] = 8'h81;
        for (int n = 0; n < 40; n++) begin
            i  = int'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            sb = 8'($urandom);
            apply_stimulus(i, rw, 7'($urandom), 8'($urandom), sb, 1'b1, lat);
            check_output("rand_latency", i, lat, 34 * div_of(i));
            if (rw) prev_rd[i] = sb;
            check_output("rand_rdata", i, rdata_v[i], prev_rd[i]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
